// File: rtl/customs_clearance_fsm.sv
// Customs clearance sequencer: docs check, inspection with bounded retries,
// transit-preparation delay, then release hold until downstream acknowledges.
module customs_clearance_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 2,
    parameter int TRANSIT_DELAY  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_shipment_arrive,
    input  logic       i_docs_valid,
    input  logic       i_docs_ok,
    input  logic       i_inspect_done,
    input  logic       i_inspect_pass,
    input  logic       i_release_ack,
    output logic       o_customs_cleared,
    output logic       o_transit_ready,
    output logic       o_rejected,
    output logic       o_busy,
    output logic [1:0] o_retry_count
);

    // state     | meaning
    // IDLE      | waiting for a shipment
    // DOCS      | awaiting documentation result
    // INSPECT   | awaiting inspection result, retries allowed
    // CLEARED   | release held until transit delay and downstream ack
    // REJECT    | one-cycle reject pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DOCS    = 3'd1;
    localparam logic [2:0] S_INSPECT = 3'd2;
    localparam logic [2:0] S_CLEARED = 3'd3;
    localparam logic [2:0] S_REJECT  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_timer;
    logic [1:0] r_retry_count;
    logic       w_retry;
    logic       w_clr_retry;
    logic       w_timer_clr;
    logic       w_timeout;
    logic       w_transit_ready;

    assign w_timeout       = (r_timer == 8'(TIMEOUT_CYCLES - 1));
    assign w_transit_ready = (r_state == S_CLEARED) && (r_timer >= 8'(TRANSIT_DELAY));

    always_comb begin
        w_state_nxt = r_state;
        w_retry     = 1'b0;
        w_clr_retry = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_shipment_arrive) begin
                    w_state_nxt = S_DOCS;
                    w_clr_retry = 1'b1;
                end
            end
            S_DOCS: begin
                // A result on the final timeout cycle wins over the timeout.
                if (i_docs_valid) begin
                    w_state_nxt = i_docs_ok ? S_INSPECT : S_REJECT;
                end else if (w_timeout) begin
                    w_state_nxt = S_REJECT;
                end
            end
            S_INSPECT: begin
                if (i_inspect_done) begin
                    if (i_inspect_pass) begin
                        w_state_nxt = S_CLEARED;
                    end else if (r_retry_count < 2'(MAX_RETRIES)) begin
                        w_retry = 1'b1;
                    end else begin
                        w_state_nxt = S_REJECT;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_REJECT;
                end
            end
            S_CLEARED: begin
                if (i_release_ack && w_transit_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REJECT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_timer_clr = (w_state_nxt != r_state) || w_retry;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_timer       <= 8'd0;
            r_retry_count <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_timer_clr) begin
                r_timer <= 8'd0;
            end else if (r_timer != 8'hFF) begin
                r_timer <= r_timer + 8'd1;
            end
            if (w_clr_retry) begin
                r_retry_count <= 2'd0;
            end else if (w_retry) begin
                r_retry_count <= r_retry_count + 2'd1;
            end
        end
    end

    assign o_customs_cleared = (r_state == S_CLEARED);
    assign o_transit_ready   = w_transit_ready;
    assign o_rejected        = (r_state == S_REJECT);
    assign o_busy            = (r_state != S_IDLE);
    assign o_retry_count     = r_retry_count;

endmodule
